// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster generator: 640x480@60 defaults, axis totals and
// the colour-bar lookup used by the optional test pattern.
package vga_timing_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefColorW  = 4;
  localparam int unsigned DefCntW    = 10;

  // Colour bars: bar index bit k drives one channel fully on or off.
  localparam int unsigned NumBars     = 8;
  localparam int unsigned BarBlueBit  = 0;
  localparam int unsigned BarGreenBit = 1;
  localparam int unsigned BarRedBit   = 2;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [2:0] bar_index(input int unsigned x, input int unsigned active);
    int unsigned idx;
    idx = (x * NumBars) / active;
    return 3'(idx);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source / DAC-side signal bundle of the VGA timing generator.
// With VGA_TEST_PATTERN_EN defined the bundle carries an extra test_mode input.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
#(
  parameter int unsigned COLOR_W = DefColorW,
  parameter int unsigned CNT_W   = DefCntW
);

  logic [3*COLOR_W-1:0] rgb_in;
  logic [CNT_W-1:0]     pix_x;
  logic [CNT_W-1:0]     pix_y;
  logic                 pix_active;
  logic [COLOR_W-1:0]   red_out;
  logic [COLOR_W-1:0]   green_out;
  logic [COLOR_W-1:0]   blue_out;
  logic                 hSync;
  logic                 vSync;
  logic                 line_start;
  logic                 frame_start;

`ifdef VGA_TEST_PATTERN_EN
  logic                 test_mode;

  modport master (
    input  rgb_in, test_mode,
    output pix_x, pix_y, pix_active, red_out, green_out, blue_out,
    output hSync, vSync, line_start, frame_start
  );

  modport slave (
    output rgb_in, test_mode,
    input  pix_x, pix_y, pix_active, red_out, green_out, blue_out,
    input  hSync, vSync, line_start, frame_start
  );
`else
  modport master (
    input  rgb_in,
    output pix_x, pix_y, pix_active, red_out, green_out, blue_out,
    output hSync, vSync, line_start, frame_start
  );

  modport slave (
    output rgb_in,
    input  pix_x, pix_y, pix_active, red_out, green_out, blue_out,
    input  hSync, vSync, line_start, frame_start
  );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with active-region and sync-window decode.
// Advances only when tick is high; wrap flags the tick that returns the count to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DefHActive,
  parameter int unsigned FP     = DefHFp,
  parameter int unsigned SYNC   = DefHSync,
  parameter int unsigned BP     = DefHBp,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync_raw
);

  localparam int unsigned Total = h_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(Total - 1);
  localparam logic [CNT_W-1:0] ActiveEnd = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SyncStart = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SyncLast  = CNT_W'(ACTIVE + FP + SYNC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;
  logic             in_sync;

  assign at_last = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Inclusive upper bound keeps the compare inside CNT_W even when BP is 0.
  assign in_sync  = (cnt_q >= SyncStart) && (cnt_q <= SyncLast);
  assign cnt      = cnt_q;
  assign wrap     = tick && at_last;
  assign active   = (cnt_q < ActiveEnd);
  assign sync_raw = in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a one-cycle registered DAC/sync output stage.
// Define VGA_TEST_PATTERN_EN to add test_mode, which replaces rgb_in with 8 colour bars.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DefHActive,
  parameter int unsigned H_FP       = DefHFp,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BP       = DefHBp,
  parameter int unsigned V_ACTIVE   = DefVActive,
  parameter int unsigned V_FP       = DefVFp,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BP       = DefVBp,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned COLOR_W    = DefColorW,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic             clk25,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             h_active, v_active;
  logic             h_sync_raw, v_sync_raw;
  logic             pix_active;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_SYNC_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk25    (clk25),
    .rst      (rst),
    .tick     (1'b1),
    .cnt      (h_cnt),
    .wrap     (h_wrap),
    .active   (h_active),
    .sync_raw (h_sync_raw)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_SYNC_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk25    (clk25),
    .rst      (rst),
    .tick     (h_wrap),
    .cnt      (v_cnt),
    .wrap     (v_wrap),
    .active   (v_active),
    .sync_raw (v_sync_raw)
  );

  assign pix_active     = h_active & v_active;
  assign vga.pix_x      = h_cnt;
  assign vga.pix_y      = v_cnt;
  assign vga.pix_active = pix_active;

  logic [3*COLOR_W-1:0] pix_rgb, rgb_d, rgb_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;

  assign bar = bar_index(32'(h_cnt), H_ACTIVE);

  always_comb begin
    pix_rgb = vga.rgb_in;
    if (vga.test_mode) begin
      pix_rgb = {{COLOR_W{bar[BarRedBit]}}, {COLOR_W{bar[BarGreenBit]}},
                 {COLOR_W{bar[BarBlueBit]}}};
    end
  end
`else
  assign pix_rgb = vga.rgb_in;
`endif

  always_comb begin
    rgb_d = pix_active ? pix_rgb : '0;
  end

  logic hsync_q, vsync_q;
  logic sol_q, sof_q;
  logic line_start_q, frame_start_q;

  // sol_q/sof_q mark that the counters currently sit on h=0 / (h=0,v=0); they are
  // set by reset (raster restarts at origin) and by the wrap that lands there.
  always_ff @(posedge clk25) begin
    if (rst) begin
      rgb_q         <= '0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      sol_q         <= 1'b1;
      sof_q         <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      hsync_q       <= h_sync_raw;
      vsync_q       <= v_sync_raw;
      sol_q         <= h_wrap;
      sof_q         <= v_wrap;
      line_start_q  <= sol_q;
      frame_start_q <= sof_q;
    end
  end

  assign vga.red_out     = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vga.green_out   = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga.blue_out    = rgb_q[COLOR_W-1 -: COLOR_W];
  assign vga.hSync       = hsync_q;
  assign vga.vSync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance and a small 8/2/2/2 x 4/1/1/1 positive-sync instance,
// both checked every cycle against a raster model derived from a cycles-since-reset count.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    bit hp; bit vp;
  } cfg_t;

  typedef struct packed {
    logic [31:0] px;
    logic [31:0] py;
    logic        act;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic [11:0] rgb_a = '0, rgb_b = '0;
  logic        psrc_a = 1'b0, psrc_b = 1'b0;
  logic        tm_a = 1'b0, tm_b = 1'b0;

  vga_timing_gen_if #(.COLOR_W(4), .CNT_W(10)) if_a ();
  vga_timing_gen_if #(.COLOR_W(4), .CNT_W(10)) if_b ();

  // Closed-loop pixel source option: colour equals the requested x coordinate.
  assign if_a.rgb_in = psrc_a ? 12'(if_a.pix_x) : rgb_a;
  assign if_b.rgb_in = psrc_b ? 12'(if_b.pix_x) : rgb_b;
`ifdef VGA_TEST_PATTERN_EN
  assign if_a.test_mode = tm_a;
  assign if_b.test_mode = tm_b;
`endif

  vga_timing_gen dut_a (
    .clk25 (clk),
    .rst   (rst_a),
    .vga   (if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE   (8),
    .H_FP       (2),
    .H_SYNC     (2),
    .H_BP       (2),
    .V_ACTIVE   (4),
    .V_FP       (1),
    .V_SYNC     (1),
    .V_BP       (1),
    .H_SYNC_POL (1'b1),
    .V_SYNC_POL (1'b1)
  ) dut_b (
    .clk25 (clk),
    .rst   (rst_b),
    .vga   (if_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, d, act, req);
    end
  endtask

  function automatic cfg_t cfg_of(input int d);
    cfg_t c;
    if (d == 0) c = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33,
                      hp: 1'b0, vp: 1'b0};
    else        c = '{ha: 8, hf: 2, hsw: 2, hb: 2, va: 4, vf: 1, vsw: 1, vb: 1,
                      hp: 1'b1, vp: 1'b1};
    return c;
  endfunction

  // Counters as seen m cycles after the raster (re)started at the origin.
  function automatic obs_t pix_of(input cfg_t c, input int m);
    obs_t o;
    int   ht, vt, x, y;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    x  = m % ht;
    y  = (m / ht) % vt;
    o  = '0;
    o.px  = 32'(x);
    o.py  = 32'(y);
    o.act = (x < c.ha) && (y < c.va);
    return o;
  endfunction

  // Pin values one cycle after coordinate index m was presented with the given inputs.
  function automatic obs_t out_of(input cfg_t c, input int m, input logic [11:0] rgb,
                                  input bit psrc, input bit tm);
    obs_t        p, o;
    int          x, y;
    logic [11:0] src;
    logic [2:0]  bar;
    p   = pix_of(c, m);
    x   = int'(p.px);
    y   = int'(p.py);
    src = psrc ? 12'(x) : rgb;
    bar = 3'((x * 8) / c.ha);
    if (tm) src = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    o     = '0;
    o.rgb = p.act ? src : 12'h000;
    o.hs  = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
    o.vs  = (y >= c.va + c.vf && y < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
    o.ls  = (x == 0);
    o.fs  = (x == 0) && (y == 0);
    return o;
  endfunction

  // Hand-computed timing facts for each instance.
  int lp_exp[2]   = '{800, 14};
  int fp_exp[2]   = '{420000, 98};
  int hs_x_exp[2] = '{656, 10};
  int hs_w_exp[2] = '{96, 2};
  int vs_w_exp[2] = '{1600, 14};

  int          n[2];
  bit          valid[2]     = '{1'b0, 1'b0};
  bit          prev_rst[2]  = '{1'b0, 1'b0};
  bit          prev2_rst[2] = '{1'b0, 1'b0};
  logic [11:0] prev_rgb[2];
  bit          prev_psrc[2], prev_tm[2];
  logic [31:0] last_px[2];
  int          hs_run[2], vs_run[2], ls_gap[2], fs_gap[2];
  bit          ls_seen[2], fs_seen[2];

  always @(negedge clk) begin
    obs_t o, e, p;
    cfg_t c;
    bit   rst_now, psrc_now, tm_now;
    logic [11:0] rgb_now;
    for (int d = 0; d < 2; d++) begin
      c = cfg_of(d);
      if (d == 0) begin
        o = {32'(if_a.pix_x), 32'(if_a.pix_y), if_a.pix_active,
             {if_a.red_out, if_a.green_out, if_a.blue_out},
             if_a.hSync, if_a.vSync, if_a.line_start, if_a.frame_start};
        rst_now = rst_a; rgb_now = rgb_a; psrc_now = psrc_a; tm_now = tm_a;
      end else begin
        o = {32'(if_b.pix_x), 32'(if_b.pix_y), if_b.pix_active,
             {if_b.red_out, if_b.green_out, if_b.blue_out},
             if_b.hSync, if_b.vSync, if_b.line_start, if_b.frame_start};
        rst_now = rst_b; rgb_now = rgb_b; psrc_now = psrc_b; tm_now = tm_b;
      end
      e = '0;
      if (prev_rst[d]) begin
        valid[d] = 1'b1;
        n[d]     = 0;
        e.hs     = ~c.hp;
        e.vs     = ~c.vp;
        hs_run[d] = 0; vs_run[d] = 0; ls_gap[d] = 0; fs_gap[d] = 0;
        ls_seen[d] = 1'b0; fs_seen[d] = 1'b0;
      end else if (valid[d]) begin
        e = out_of(c, n[d], prev_rgb[d], prev_psrc[d], prev_tm[d]);
        n[d]++;
      end
      if (valid[d]) begin
        p = pix_of(c, n[d]);
        chk("pix_x", d, o.px, p.px);
        chk("pix_y", d, o.py, p.py);
        chk("pix_active", d, 32'(o.act), 32'(p.act));
        chk("rgb_out", d, 32'(o.rgb), 32'(e.rgb));
        chk("hSync", d, 32'(o.hs), 32'(e.hs));
        chk("vSync", d, 32'(o.vs), 32'(e.vs));
        chk("line_start", d, 32'(o.ls), 32'(e.ls));
        chk("frame_start", d, 32'(o.fs), 32'(e.fs));
        if (!prev_rst[d]) begin
          if (prev2_rst[d]) chk("first_frame_start", d, 32'(o.fs), 32'd1);
          ls_gap[d]++;
          fs_gap[d]++;
          if (o.ls === 1'b1) begin
            if (ls_seen[d]) chk("line_period", d, 32'(ls_gap[d]), 32'(lp_exp[d]));
            ls_seen[d] = 1'b1;
            ls_gap[d]  = 0;
          end
          if (o.fs === 1'b1) begin
            if (fs_seen[d]) chk("frame_period", d, 32'(fs_gap[d]), 32'(fp_exp[d]));
            fs_seen[d] = 1'b1;
            fs_gap[d]  = 0;
          end
          if (o.hs === c.hp) begin
            if (hs_run[d] == 0) chk("hsync_start_x", d, last_px[d], 32'(hs_x_exp[d]));
            hs_run[d]++;
          end else begin
            if (hs_run[d] != 0) chk("hsync_width", d, 32'(hs_run[d]), 32'(hs_w_exp[d]));
            hs_run[d] = 0;
          end
          if (o.vs === c.vp) begin
            vs_run[d]++;
          end else begin
            if (vs_run[d] != 0) chk("vsync_width", d, 32'(vs_run[d]), 32'(vs_w_exp[d]));
            vs_run[d] = 0;
          end
        end
      end
      last_px[d]   = o.px;
      prev2_rst[d] = prev_rst[d];
      prev_rst[d]  = rst_now;
      prev_rgb[d]  = rgb_now;
      prev_psrc[d] = psrc_now;
      prev_tm[d]   = tm_now;
    end
  end

  // Default mode: random, constant 'hABC and closed-loop colour, then reset at (300,5).
  task automatic drive_a();
    repeat (4) @(posedge clk);
    #1 rst_a = 1'b0;
    rgb_a = 12'($urandom);
    for (int i = 1; i < 4300; i++) begin
      @(posedge clk);
      #1;
      if (i < 1500)      rgb_a = 12'($urandom);
      else if (i < 3000) rgb_a = 12'hABC;
      else               psrc_a = 1'b1;
    end
    @(posedge clk);
    #1 rst_a = 1'b1;
    psrc_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    for (int i = 0; i < 16000; i++) begin
      rgb_a = 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
      tm_a = (i < 4000);
`endif
      @(posedge clk);
      #1;
    end
  endtask

  // Small mode: reset at (3,2), then random-length runs separated by random resets.
  task automatic drive_b();
    repeat (4) @(posedge clk);
    #1 rst_b = 1'b0;
    for (int i = 0; i < 31; i++) begin
      rgb_b = 12'($urandom);
      @(posedge clk);
      #1;
    end
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    for (int r = 0; r < 60; r++) begin
      int len;
      len    = int'($urandom_range(300, 20));
      psrc_b = (($urandom % 4) == 0);
      for (int i = 0; i < len; i++) begin
        rgb_b = 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
        tm_b = (($urandom % 3) == 0);
`endif
        @(posedge clk);
        #1;
      end
      rst_b = 1'b1;
      repeat (int'($urandom_range(3, 1))) @(posedge clk);
      #1 rst_b = 1'b0;
    end
  endtask

  initial begin
    fork
      drive_a();
      drive_b();
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
